// File: rtl/chimera_wide_mem_responder.sv
// AXI4 subordinate terminating the cluster wide-out port onto one single-port SRAM bank.
// One burst at a time; reads stream through a 2-entry buffer at one beat per cycle.
module chimera_wide_mem_responder #(
    parameter int unsigned AddrWidth    = 48,
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned MemAddrWidth = 14
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AddrWidth-1:0]       region_base_i,
    input  logic                       aw_valid_i,
    output logic                       aw_ready_o,
    input  logic [IdWidth-1:0]         aw_id_i,
    input  logic [AddrWidth-1:0]       aw_addr_i,
    input  logic [7:0]                 aw_len_i,
    input  logic [2:0]                 aw_size_i,
    input  logic [1:0]                 aw_burst_i,
    input  logic                       w_valid_i,
    output logic                       w_ready_o,
    input  logic [DataWidth-1:0]       w_data_i,
    input  logic [DataWidth/8-1:0]     w_strb_i,
    input  logic                       w_last_i,
    output logic                       b_valid_o,
    input  logic                       b_ready_i,
    output logic [IdWidth-1:0]         b_id_o,
    output logic [1:0]                 b_resp_o,
    input  logic                       ar_valid_i,
    output logic                       ar_ready_o,
    input  logic [IdWidth-1:0]         ar_id_i,
    input  logic [AddrWidth-1:0]       ar_addr_i,
    input  logic [7:0]                 ar_len_i,
    input  logic [2:0]                 ar_size_i,
    input  logic [1:0]                 ar_burst_i,
    output logic                       r_valid_o,
    input  logic                       r_ready_i,
    output logic [IdWidth-1:0]         r_id_o,
    output logic [DataWidth-1:0]       r_data_o,
    output logic [1:0]                 r_resp_o,
    output logic                       r_last_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [MemAddrWidth-1:0]    mem_addr_o,
    output logic [DataWidth-1:0]       mem_wdata_o,
    output logic [DataWidth/8-1:0]     mem_be_o,
    input  logic [DataWidth-1:0]       mem_rdata_i
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned LowW      = MemAddrWidth + OffW;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef enum logic [1:0] {StIdle, StWrite, StWResp, StRead} state_e;
    state_e state_q, state_d;

    logic [IdWidth-1:0]   id_q;
    logic [LowW-1:0]      addr_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [1:0]           err_q;
    logic [7:0]           beat_cnt_q;
    logic [8:0]           rd_issued_q;
    logic                 inflight_q;
    logic                 prio_w_q;
    logic                 en_q;
    logic [DataWidth-1:0] buf_q [2];
    logic                 buf_wr_ptr_q;
    logic                 buf_rd_ptr_q;
    logic [1:0]           buf_cnt_q;

    logic                 grant_w, aw_hs, ar_hs, w_hs, r_hs, last_beat, rd_issue;
    logic [2:0]           rd_occ;
    logic [LowW-1:0]      step;
    logic [AddrWidth-1:0] req_addr;
    logic [2:0]           req_size;
    logic [1:0]           req_burst;
    logic                 unused_base;

    function automatic logic [1:0] calc_err(input logic [AddrWidth-1:0] a,
                                            input logic [AddrWidth-1:0] base,
                                            input logic [2:0] sz,
                                            input logic [1:0] bu);
        if (a[AddrWidth-1:LowW] != base[AddrWidth-1:LowW]) return RespDecErr;
        if (bu == BurstWrap || 32'(sz) > OffW) return RespSlvErr;
        return RespOkay;
    endfunction

    assign unused_base = ^region_base_i[LowW-1:0];
    assign grant_w   = aw_valid_i & (prio_w_q | ~ar_valid_i);
    assign aw_hs     = aw_valid_i & aw_ready_o;
    assign ar_hs     = ar_valid_i & ar_ready_o;
    assign w_hs      = w_valid_i & w_ready_o;
    assign r_valid_o = buf_cnt_q != 2'd0;
    assign r_hs      = r_valid_o & r_ready_i;
    assign last_beat = beat_cnt_q == len_q;
    assign step      = LowW'(1) << size_q;
    assign req_addr  = aw_hs ? aw_addr_i : ar_addr_i;
    assign req_size  = aw_hs ? aw_size_i : ar_size_i;
    assign req_burst = aw_hs ? aw_burst_i : ar_burst_i;

    // A same-cycle pop frees a slot, which is what sustains one beat per cycle.
    assign rd_occ   = 3'(buf_cnt_q) + 3'(inflight_q);
    assign rd_issue = (state_q == StRead) && ({1'b0, len_q} >= rd_issued_q)
                      && (rd_occ < 3'd2 + 3'(r_hs));

    assign b_id_o      = id_q;
    assign b_resp_o    = err_q;
    assign r_id_o      = id_q;
    assign r_resp_o    = err_q;
    assign r_data_o    = buf_q[buf_rd_ptr_q];
    assign r_last_o    = r_valid_o & last_beat;
    assign mem_addr_o  = addr_q[LowW-1:OffW];
    assign mem_wdata_o = w_data_i;
    assign mem_be_o    = mem_we_o ? w_strb_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        aw_ready_o = 1'b0;
        ar_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                aw_ready_o = en_q & grant_w;
                ar_ready_o = en_q & ~grant_w;
                if (aw_valid_i && en_q && grant_w)       state_d = StWrite;
                else if (ar_valid_i && en_q && !grant_w) state_d = StRead;
            end
            StWrite: begin
                w_ready_o = 1'b1;
                if (w_valid_i && err_q == RespOkay) begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                end
                if (w_valid_i && last_beat) state_d = StWResp;
            end
            StWResp: begin
                b_valid_o = 1'b1;
                if (b_ready_i) state_d = StIdle;
            end
            StRead: begin
                mem_req_o = rd_issue && err_q == RespOkay;
                if (r_hs && last_beat) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst context: latched on accept, advanced per write beat / read issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= RespOkay;
            beat_cnt_q  <= '0;
            rd_issued_q <= '0;
            inflight_q  <= 1'b0;
            prio_w_q    <= 1'b1;
            en_q        <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            inflight_q <= rd_issue;
            if (aw_hs || ar_hs) begin
                id_q        <= aw_hs ? aw_id_i : ar_id_i;
                addr_q      <= req_addr[LowW-1:0];
                len_q       <= aw_hs ? aw_len_i : ar_len_i;
                size_q      <= req_size;
                burst_q     <= req_burst;
                err_q       <= calc_err(req_addr, region_base_i, req_size, req_burst);
                beat_cnt_q  <= '0;
                rd_issued_q <= '0;
                prio_w_q    <= ar_hs;
            end
            if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
                if (burst_q != BurstFixed) addr_q <= addr_q + step;
                if (w_last_i != last_beat) err_q <= RespSlvErr;
            end
            if (rd_issue) begin
                rd_issued_q <= rd_issued_q + 9'd1;
                if (burst_q != BurstFixed) addr_q <= addr_q + step;
            end
            if (r_hs) beat_cnt_q <= beat_cnt_q + 8'd1;
        end
    end

    // Two-entry read buffer; error bursts push zero words instead of SRAM data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            buf_wr_ptr_q <= 1'b0;
            buf_rd_ptr_q <= 1'b0;
            buf_cnt_q    <= '0;
        end else begin
            if (inflight_q) begin
                buf_q[buf_wr_ptr_q] <= (err_q == RespOkay) ? mem_rdata_i : '0;
                buf_wr_ptr_q        <= ~buf_wr_ptr_q;
            end
            if (r_hs) buf_rd_ptr_q <= ~buf_rd_ptr_q;
            buf_cnt_q <= buf_cnt_q + 2'(inflight_q) - 2'(r_hs);
        end
    end
endmodule

// File: tb/tb_chimera_wide_mem_responder.sv
// Directed bench for chimera_wide_mem_responder with a 1-cycle-latency SRAM model.
module tb_chimera_wide_mem_responder;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 512;
    localparam int unsigned IW = 4;
    localparam int unsigned MW = 14;
    localparam int unsigned SW = DW / 8;
    localparam logic [AW-1:0] Base = 48'h0000_1230_0000;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [AW-1:0] region_base_i;
    logic aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, w_last_i, b_valid_o, b_ready_i;
    logic ar_valid_i, ar_ready_o, r_valid_o, r_ready_i, r_last_o;
    logic [IW-1:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
    logic [AW-1:0] aw_addr_i, ar_addr_i;
    logic [7:0] aw_len_i, ar_len_i;
    logic [2:0] aw_size_i, ar_size_i;
    logic [1:0] aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
    logic [DW-1:0] w_data_i, r_data_o, mem_wdata_o, mem_rdata_i;
    logic [SW-1:0] w_strb_i, mem_be_o;
    logic mem_req_o, mem_we_o;
    logic [MW-1:0] mem_addr_o;

    chimera_wide_mem_responder dut (
        .clk_i(clk_i), .rst_i(rst_i), .region_base_i(region_base_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor state: written only by the negedge monitor process.
    logic [DW-1:0] mem_model [64];
    bit            model_init = 1'b0;
    int            wr_cnt = 0, rd_cnt = 0, w_hs_cnt = 0, out_cnt = 0, out_viol = 0;
    int            last_wr_addr = -1;
    bit            rd_pend = 1'b0;
    logic [5:0]    rd_addr = '0;
    logic [DW-1:0] r_data_q [$];
    logic          r_last_q [$];
    logic [1:0]    r_resp_q [$];
    logic [IW-1:0] r_id_q [$];
    int            r_cyc_q [$];
    int            rd_cyc_q [$];
    bit            track_out = 1'b0;

    function automatic logic [DW-1:0] init_word(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(k);
        return {16{w}};
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) if (rd_pend) mem_rdata_i <= mem_model[rd_addr];

    always @(negedge clk_i) begin
        bit rd_now, rhs;
        if (!model_init) begin
            for (int k = 0; k < 64; k++) mem_model[k] = init_word(k);
            model_init = 1'b1;
        end
        rd_now = !rst_i && mem_req_o && !mem_we_o;
        rhs    = !rst_i && r_valid_o && r_ready_i;
        if (!rst_i && mem_req_o && mem_we_o) begin
            for (int b = 0; b < SW; b++)
                if (mem_be_o[b]) mem_model[mem_addr_o[5:0]][b*8 +: 8] = mem_wdata_o[b*8 +: 8];
            wr_cnt++;
            last_wr_addr = int'(mem_addr_o);
        end
        if (rd_now) begin
            rd_cnt++;
            rd_cyc_q.push_back(cyc);
            rd_addr = mem_addr_o[5:0];
        end
        rd_pend = rd_now;
        if (!rst_i && w_valid_i && w_ready_o) w_hs_cnt++;
        if (rhs) begin
            r_data_q.push_back(r_data_o);
            r_last_q.push_back(r_last_o);
            r_resp_q.push_back(r_resp_o);
            r_id_q.push_back(r_id_o);
            r_cyc_q.push_back(cyc);
        end
        if (!track_out || rst_i) out_cnt = 0;
        else out_cnt = out_cnt + int'(rd_now) - int'(rhs);
        if (out_cnt > 2) out_viol++;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit hs = 1'b0;
        aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = 3'd6; aw_burst_i = burst;
        aw_valid_i = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_i);
            hs = aw_ready_o;
            step();
        end
        aw_valid_i = 1'b0;
        check_eq("aw_accept", DW'(hs), DW'(1));
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit hs = 1'b0;
        ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = 3'd6; ar_burst_i = burst;
        ar_valid_i = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_i);
            hs = ar_ready_o;
            step();
        end
        ar_valid_i = 1'b0;
        check_eq("ar_accept", DW'(hs), DW'(1));
    endtask

    task automatic send_w(input logic [DW-1:0] data, input logic last);
        bit hs = 1'b0;
        w_data_i = data; w_strb_i = '1; w_last_i = last; w_valid_i = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_i);
            hs = w_ready_o;
            step();
        end
        w_valid_i = 1'b0;
        check_eq("w_accept", DW'(hs), DW'(1));
    endtask

    task automatic wait_b(input logic [IW-1:0] id, input logic [1:0] resp);
        bit hs = 1'b0;
        logic [IW-1:0] gid = '0;
        logic [1:0] gresp = '0;
        b_ready_i = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_i);
            hs = b_valid_o;
            gid = b_id_o;
            gresp = b_resp_o;
            step();
        end
        b_ready_i = 1'b0;
        check_eq("b_seen", DW'(hs), DW'(1));
        check_eq("b_id", DW'(gid), DW'(id));
        check_eq("b_resp", DW'(gresp), DW'(resp));
    endtask

    task automatic collect_r(input int target, input bit toggle);
        for (int i = 0; i < 200 && r_data_q.size() < target; i++) begin
            r_ready_i = toggle ? ((i % 2) == 0) : 1'b1;
            step();
        end
        r_ready_i = 1'b0;
        check_eq("r_count_reached", DW'(r_data_q.size() >= target), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, rdb, wb, hb, n, vb;
        logic [5:0] order;
        logic [3:0] lasts;
        logic [DW-1:0] a5;
        a5 = {64{8'hA5}};
        rst_i = 1'b1; region_base_i = Base;
        aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0;
        ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0;
        w_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_last_i = 0; b_ready_i = 0; r_ready_i = 0;
        repeat (2) step();
        @(negedge clk_i);
        check_eq("rst_aw_ready", DW'(aw_ready_o), DW'(0));
        check_eq("rst_ar_ready", DW'(ar_ready_o), DW'(0));
        check_eq("rst_w_ready", DW'(w_ready_o), DW'(0));
        check_eq("rst_b_valid", DW'(b_valid_o), DW'(0));
        check_eq("rst_r_valid", DW'(r_valid_o), DW'(0));
        check_eq("rst_mem_req", DW'(mem_req_o), DW'(0));
        step();
        rst_i = 1'b0;
        step();

        // Arbitration with both request channels saturated from reset.
        aw_id_i = 4'd9; aw_addr_i = Base + 48'h800; aw_len_i = 0; aw_size_i = 3'd6; aw_burst_i = 2'b01;
        ar_id_i = 4'd10; ar_addr_i = Base + 48'h800; ar_len_i = 0; ar_size_i = 3'd6; ar_burst_i = 2'b01;
        w_data_i = {16{32'h5A5A_0001}}; w_strb_i = '1; w_last_i = 1'b1;
        w_valid_i = 1; b_ready_i = 1; r_ready_i = 1; aw_valid_i = 1; ar_valid_i = 1;
        order = '0; n = 0;
        for (int i = 0; i < 300 && n < 6; i++) begin
            @(negedge clk_i);
            if (aw_valid_i && aw_ready_o) begin order = {order[4:0], 1'b1}; n++; end
            else if (ar_valid_i && ar_ready_o) begin order = {order[4:0], 1'b0}; n++; end
            step();
        end
        aw_valid_i = 0; ar_valid_i = 0; w_valid_i = 0;
        repeat (8) step();
        b_ready_i = 0; r_ready_i = 0;
        check_eq("arb_count", DW'(n), DW'(6));
        check_eq("arb_order", DW'(order), DW'(6'b101010));

        // Single-beat write then read back at word 1.
        wb = wr_cnt;
        send_aw(4'd3, Base + 48'h40, 8'd0, 2'b01);
        send_w(a5, 1'b1);
        wait_b(4'd3, 2'b00);
        check_eq("wr_count", DW'(wr_cnt - wb), DW'(1));
        check_eq("wr_addr", DW'(last_wr_addr), DW'(1));
        rb = r_data_q.size();
        send_ar(4'd5, Base + 48'h40, 8'd0, 2'b01);
        collect_r(rb + 1, 1'b0);
        check_eq("rd1_data", r_data_q[rb], a5);
        check_eq("rd1_last", DW'(r_last_q[rb]), DW'(1));
        check_eq("rd1_resp", DW'(r_resp_q[rb]), DW'(0));
        check_eq("rd1_id", DW'(r_id_q[rb]), DW'(5));

        // Streaming read, ready held high.
        rb = r_data_q.size(); rdb = rd_cyc_q.size();
        send_ar(4'd1, Base + 48'h100, 8'd3, 2'b01);
        collect_r(rb + 4, 1'b0);
        lasts = '0;
        for (int i = 0; i < 4; i++) begin
            check_eq("stream_data", r_data_q[rb+i], init_word(4 + i));
            lasts[i] = r_last_q[rb+i];
        end
        check_eq("stream_last", DW'(lasts), DW'(4'b1000));
        check_eq("stream_rd_count", DW'(rd_cyc_q.size() - rdb), DW'(4));
        check_eq("stream_rd_consec", DW'(rd_cyc_q[rdb+3] - rd_cyc_q[rdb]), DW'(3));
        check_eq("stream_r_consec", DW'(r_cyc_q[rb+3] - r_cyc_q[rb]), DW'(3));

        // Streaming read, ready toggling 1010.
        rb = r_data_q.size(); vb = out_viol;
        track_out = 1'b1;
        send_ar(4'd2, Base + 48'h200, 8'd3, 2'b01);
        collect_r(rb + 4, 1'b1);
        r_ready_i = 1'b1;
        repeat (5) step();
        r_ready_i = 1'b0;
        track_out = 1'b0;
        check_eq("toggle_beats", DW'(r_data_q.size() - rb), DW'(4));
        for (int i = 0; i < 4; i++) check_eq("toggle_data", r_data_q[rb+i], init_word(8 + i));
        check_eq("toggle_outstanding", DW'(out_viol - vb), DW'(0));

        // WRAP read returns SLVERR zero beats with no SRAM access.
        rb = r_data_q.size(); rdb = rd_cnt;
        send_ar(4'd2, Base, 8'd1, 2'b10);
        collect_r(rb + 2, 1'b0);
        check_eq("wrap_resp0", DW'(r_resp_q[rb]), DW'(2'b10));
        check_eq("wrap_resp1", DW'(r_resp_q[rb+1]), DW'(2'b10));
        check_eq("wrap_data0", r_data_q[rb], DW'(0));
        check_eq("wrap_data1", r_data_q[rb+1], DW'(0));
        check_eq("wrap_last", DW'({r_last_q[rb+1], r_last_q[rb]}), DW'(2'b10));
        check_eq("wrap_no_mem", DW'(rd_cnt - rdb), DW'(0));

        // Out-of-region write: DECERR, beats drained, SRAM untouched.
        wb = wr_cnt; hb = w_hs_cnt;
        send_aw(4'd7, Base + 48'h10_0000, 8'd1, 2'b01);
        send_w({16{32'hDEAD_BEEF}}, 1'b0);
        send_w({16{32'hDEAD_BEEF}}, 1'b1);
        wait_b(4'd7, 2'b11);
        check_eq("decerr_no_mem", DW'(wr_cnt - wb), DW'(0));
        check_eq("decerr_beats", DW'(w_hs_cnt - hb), DW'(2));

        // Early w_last: all three beats consumed, SLVERR.
        hb = w_hs_cnt;
        send_aw(4'd6, Base + 48'hC00, 8'd2, 2'b01);
        send_w({16{32'h0000_0001}}, 1'b0);
        send_w({16{32'h0000_0002}}, 1'b1);
        send_w({16{32'h0000_0003}}, 1'b0);
        wait_b(4'd6, 2'b10);
        check_eq("wlast_beats", DW'(w_hs_cnt - hb), DW'(3));

        // Reset during beat 2 of a len 7 read.
        rb = r_data_q.size();
        send_ar(4'd4, Base + 48'h400, 8'd7, 2'b01);
        r_ready_i = 1'b1;
        for (int i = 0; i < 50 && r_data_q.size() < rb + 2; i++) step();
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("midrst_r_valid", DW'(r_valid_o), DW'(0));
        check_eq("midrst_mem_req", DW'(mem_req_o), DW'(0));
        step();
        rst_i = 1'b0;
        repeat (3) step();
        @(negedge clk_i);
        check_eq("postrst_ar_ready", DW'(ar_ready_o), DW'(1));
        check_eq("postrst_r_valid", DW'(r_valid_o), DW'(0));
        check_eq("postrst_b_valid", DW'(b_valid_o), DW'(0));
        step();
        r_ready_i = 1'b0;
        check_eq("aborted_beats", DW'(r_data_q.size() - rb), DW'(2));
        check_eq("aborted_data0", r_data_q[rb], init_word(16));
        check_eq("aborted_data1", r_data_q[rb+1], init_word(17));
        rb = r_data_q.size();
        send_ar(4'd11, Base + 48'h40, 8'd0, 2'b01);
        collect_r(rb + 1, 1'b0);
        check_eq("postrst_data", r_data_q[rb], a5);
        check_eq("postrst_resp", DW'(r_resp_q[rb]), DW'(0));
        check_eq("postrst_last", DW'(r_last_q[rb]), DW'(1));
        check_eq("postrst_id", DW'(r_id_q[rb]), DW'(11));

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
